// File: rtl/io_out_buffer.sv
// Captures execute-stage IO results into a FIFO and serializes each word MSB-first over a byte valid/ready link.
// Optional: define IO_OUT_FRAME_MARKER_EN to prefix every word with an 8'hA5 header byte.
module io_out_buffer #(
   parameter int WIDTH        = 24,
   parameter int ADDRESSWIDTH = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    captureEnable,
   input  logic [WIDTH-1:0]        dataIn,
   input  logic                    byteReady,
   input  logic                    clearOverflow,
   output logic                    byteValid,
   output logic [7:0]              byteOut,
   output logic                    full,
   output logic                    empty,
   output logic [ADDRESSWIDTH:0]   count,
   output logic                    overflow
);

   localparam int DEPTH     = 1 << ADDRESSWIDTH;
   localparam int NUM_BYTES = WIDTH / 8;
   localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_BYTES - 1);
   localparam logic [ADDRESSWIDTH:0] DEPTH_CNT = (ADDRESSWIDTH + 1)'(DEPTH);

`ifdef IO_OUT_FRAME_MARKER_EN
   typedef enum logic [1:0] {IDLE, HEADER, SEND} state_t;
`else
   typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

   state_t                  state_q, state_d;
   logic [WIDTH-1:0]        mem [DEPTH];
   logic [ADDRESSWIDTH-1:0] wrPtr_q, wrPtr_d;
   logic [ADDRESSWIDTH-1:0] rdPtr_q, rdPtr_d;
   logic [ADDRESSWIDTH:0]   count_q, count_d;
   logic                    overflow_q, overflow_d;
   logic [WIDTH-1:0]        shiftReg_q, shiftReg_d;
   logic [IDX_W-1:0]        byteIdx_q, byteIdx_d;
   logic [7:0]              byteOut_q, byteOut_d;
   logic                    push, drop, pop;

   assign full     = (count_q == DEPTH_CNT);
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign overflow = overflow_q;
   assign byteOut  = byteOut_q;

   // full is judged before the edge, so a same-cycle pop never makes room for a push
   assign push = captureEnable && !full;
   assign drop = captureEnable && full;

   always_comb begin
      state_d    = state_q;
      shiftReg_d = shiftReg_q;
      byteIdx_d  = byteIdx_q;
      byteOut_d  = byteOut_q;
      pop        = 1'b0;
      byteValid  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               shiftReg_d = mem[rdPtr_q];
               byteIdx_d  = '0;
`ifdef IO_OUT_FRAME_MARKER_EN
               byteOut_d  = 8'hA5;
               state_d    = HEADER;
`else
               byteOut_d  = mem[rdPtr_q][WIDTH-1 -: 8];
               state_d    = SEND;
`endif
            end
         end
`ifdef IO_OUT_FRAME_MARKER_EN
         HEADER: begin
            byteValid = 1'b1;
            if (byteReady) begin
               byteOut_d = shiftReg_q[WIDTH-1 -: 8];
               state_d   = SEND;
            end
         end
`endif
         SEND: begin
            byteValid = 1'b1;
            if (byteReady) begin
               shiftReg_d = shiftReg_q << 8;
               byteIdx_d  = byteIdx_q + IDX_W'(1);
               // byteOut keeps the final byte while idle
               if (byteIdx_q == LAST_IDX) begin
                  state_d = IDLE;
               end else begin
                  byteOut_d = shiftReg_d[WIDTH-1 -: 8];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wrPtr_d    = push ? wrPtr_q + 1'b1 : wrPtr_q;
      rdPtr_d    = pop ? rdPtr_q + 1'b1 : rdPtr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
      if (drop) begin
         overflow_d = 1'b1;
      end else if (clearOverflow) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wrPtr_q] <= dataIn;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         shiftReg_q <= '0;
         byteIdx_q  <= '0;
         byteOut_q  <= '0;
      end else begin
         state_q    <= state_d;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         shiftReg_q <= shiftReg_d;
         byteIdx_q  <= byteIdx_d;
         byteOut_q  <= byteOut_d;
      end
   end

endmodule

// File: tb/tb_io_out_buffer.sv
// Directed self-checking bench for io_out_buffer; expected byte streams are built from the captured words.
module tb_io_out_buffer;

   logic        clock = 1'b0;
   logic        reset;
   logic        captureEnable;
   logic [23:0] dataIn;
   logic        byteReady;
   logic        clearOverflow;
   logic        byteValid;
   logic [7:0]  byteOut;
   logic        full;
   logic        empty;
   logic [4:0]  count;
   logic        overflow;

   int total = 0;
   int bad   = 0;
   logic [7:0] expQ[$];
   logic [7:0] gotQ[$];
   int cycles;
   int maxCount;

   io_out_buffer #(.WIDTH(24), .ADDRESSWIDTH(4)) dut (
      .clock(clock), .reset(reset), .captureEnable(captureEnable), .dataIn(dataIn),
      .byteReady(byteReady), .clearOverflow(clearOverflow), .byteValid(byteValid),
      .byteOut(byteOut), .full(full), .empty(empty), .count(count), .overflow(overflow)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [23:0] word);
      captureEnable = 1'b1;
      dataIn        = word;
      step();
      captureEnable = 1'b0;
   endtask

   task automatic expectWord(input logic [23:0] word);
`ifdef IO_OUT_FRAME_MARKER_EN
      expQ.push_back(8'hA5);
`endif
      expQ.push_back(word[23:16]);
      expQ.push_back(word[15:8]);
      expQ.push_back(word[7:0]);
   endtask

   // Accept bytes with byteReady held high until the expected stream length is reached or the budget runs out
   task automatic drainBytes(input string tag, input int budget, output int usedCycles, output int peakCount);
      logic [31:0] got;
      gotQ.delete();
      usedCycles = 0;
      peakCount  = 0;
      byteReady  = 1'b1;
      while (gotQ.size() < expQ.size() && usedCycles < budget) begin
         if (byteValid) gotQ.push_back(byteOut);
         if (int'(count) > peakCount) peakCount = int'(count);
         step();
         usedCycles++;
      end
      checkOutput({tag, "_len"}, gotQ.size(), expQ.size());
      for (int i = 0; i < expQ.size(); i++) begin
         got = (i < gotQ.size()) ? {24'h0, gotQ[i]} : 32'hDEADBEEF;
         checkOutput($sformatf("%s_b%0d", tag, i), got, {24'h0, expQ[i]});
      end
      expQ.delete();
   endtask

   initial begin
      reset         = 1'b1;
      captureEnable = 1'b0;
      dataIn        = '0;
      byteReady     = 1'b0;
      clearOverflow = 1'b0;
      step();
      step();
      checkOutput("rst_valid", byteValid, 0);
      checkOutput("rst_byte", byteOut, 0);
      checkOutput("rst_full", full, 0);
      checkOutput("rst_empty", empty, 1);
      checkOutput("rst_count", count, 0);
      checkOutput("rst_ovf", overflow, 0);
      reset = 1'b0;
      step();

      // single word with sink always ready
      byteReady = 1'b1;
      applyStimulus(24'h123456);
      checkOutput("single_cnt1", count, 1);
      step();
      checkOutput("single_lat", byteValid, 1);
      expectWord(24'h123456);
      drainBytes("single", 20, cycles, maxCount);
      checkOutput("single_consec", cycles, expQ.size() == 0 ? gotQ.size() : 0);
      checkOutput("single_empty", empty, 1);
      checkOutput("single_count", count, 0);
      checkOutput("single_valid", byteValid, 0);
      checkOutput("single_hold", byteOut, 8'h56);

      // backpressure holds first byte stable
      byteReady = 1'b0;
      applyStimulus(24'hABCDEF);
      step();
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("bp_valid%0d", i), byteValid, 1);
`ifdef IO_OUT_FRAME_MARKER_EN
         checkOutput($sformatf("bp_byte%0d", i), byteOut, 8'hA5);
`else
         checkOutput($sformatf("bp_byte%0d", i), byteOut, 8'hAB);
`endif
         step();
      end
      expectWord(24'hABCDEF);
      drainBytes("bp", 20, cycles, maxCount);
      step();
      checkOutput("bp_empty", empty, 1);

      // fill, overflow, clear, drop-beats-clear, then drain in order
      byteReady = 1'b0;
      for (int i = 0; i < 17; i++) begin
         captureEnable = 1'b1;
         dataIn        = 24'(i);
         step();
      end
      captureEnable = 1'b0;
      checkOutput("fill_full", full, 1);
      checkOutput("fill_count", count, 16);
      checkOutput("fill_empty", empty, 0);
      checkOutput("fill_ovf0", overflow, 0);
      applyStimulus(24'h000011);
      checkOutput("ovf_set", overflow, 1);
      checkOutput("ovf_count", count, 16);
      clearOverflow = 1'b1;
      step();
      clearOverflow = 1'b0;
      checkOutput("ovf_clear", overflow, 0);
      clearOverflow = 1'b1;
      applyStimulus(24'h000011);
      clearOverflow = 1'b0;
      checkOutput("ovf_dropwins", overflow, 1);
      clearOverflow = 1'b1;
      step();
      clearOverflow = 1'b0;
      checkOutput("ovf_clear2", overflow, 0);
      for (int i = 0; i < 17; i++) expectWord(24'(i));
      drainBytes("fill", 300, cycles, maxCount);
      step();
      step();
      checkOutput("fill_drained", empty, 1);
      checkOutput("fill_nomore", byteValid, 0);

      // second capture lands while the first word is being sent
      byteReady = 1'b1;
      applyStimulus(24'h000001);
      checkOutput("cc_cnt1", count, 1);
      applyStimulus(24'h000002);
      checkOutput("cc_cnt2", count, 1);
      expectWord(24'h000001);
      expectWord(24'h000002);
      drainBytes("cc", 30, cycles, maxCount);
      checkOutput("cc_peak", maxCount, 1);

      // asynchronous reset after the first byte was accepted
      byteReady = 1'b1;
      applyStimulus(24'h112233);
      step();
      step();
      reset = 1'b1;
      #1;
      checkOutput("ar_valid", byteValid, 0);
      checkOutput("ar_count", count, 0);
      checkOutput("ar_empty", empty, 1);
      step();
      reset = 1'b0;
      step();
      applyStimulus(24'h445566);
      expectWord(24'h445566);
      drainBytes("ar", 20, cycles, maxCount);
      step();
      step();
      checkOutput("ar_done", byteValid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
